mandel_scan_sequencer: RTL and testbench
========================================

# mandel_scan_sequencer

Host-side sequencer that sits directly upstream of the Mandelbrot accelerator core and drives its load/start/data pins. It walks a rectangular pixel grid, computes each pixel's fixed-point complex coordinate incrementally, and loads Cr and Ci byte-serially. It then pulses start, waits for the core's done flag, and emits the iteration count on a valid/ready pixel stream.

## Interface
Parameters:
- `TIMEOUT`, 1023: max WAIT cycles before the pixel is forced out as timed-out; 10-bit counter.

Ports:
- `clk`  in  1  system clock; all logic rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_frame`  in  1  one-cycle request; sampled only in IDLE.
- `cfg_x0`, `cfg_y0`  in  16 each  signed Q4.12 origin (top-left Cr, Ci).
- `cfg_dx`, `cfg_dy`  in  16 each  signed Q4.12 per-pixel step.
- `cfg_w`, `cfg_h`  in  8 each  grid width/height in pixels.
- `busy`  out  1  high from the cycle after accepted `start_frame` until `frame_done`.
- `frame_done`  out  1  one-cycle pulse after the last pixel handshake.
- `acc_load_cr`, `acc_load_ci`, `acc_start`  out  1 each  accelerator strobes.
- `acc_data`  out  8  accelerator byte bus.
- `acc_done`  in  1  accelerator finished; level, valid while high.
- `acc_iter`  in  7  iteration count, valid while `acc_done` high.
- `pix_valid`  out  1  pixel result valid.
- `pix_ready`  in  1  downstream accepts.
- `pix_data`  out  8  {timeout flag, iter[6:0]}.
- `pix_x`, `pix_y`  out  8 each  pixel coordinates.
- `pix_last`  out  1  high with the final pixel of the frame.

## Operation
- Reset: all outputs 0; FSM to IDLE; coordinate accumulators and counters cleared.
- Config sampled into registers on accepted `start_frame`; later changes ignored until the next frame.
- `start_frame` while busy: ignored.
- `cfg_w==0` or `cfg_h==0`: no pixels; IDLE -> DONE -> IDLE, `frame_done` pulses one cycle later, `busy` high for that cycle only.
- States: IDLE, LCR0, LCR1, LCI0, LCI1, START, WAIT, OUT, ADV, DONE.
- LCR0/LCR1: `acc_load_cr`=1, `acc_data`=cr[7:0] then cr[15:8]. LCI0/LCI1: same with `acc_load_ci` and ci. Only one strobe high at a time; `acc_data`=0 otherwise.
- START: `acc_start`=1 for exactly one cycle.
- WAIT: counts cycles; `acc_done`=1 -> OUT with `pix_data`={0,acc_iter}; counter reaching TIMEOUT without done -> OUT with `pix_data`=0xFF.
- OUT: `pix_valid`=1, outputs held stable until `pix_ready`; on handshake -> ADV, or DONE if last pixel.
- ADV: x+=1, cr+=dx; at x==w-1 wrap x=0, cr=x0, y+=1, ci+=dy; then LCR0.
- Coordinate arithmetic: 16-bit two's-complement add, wraps modulo 2^16, no saturation.
- Raster order: x fastest, row-major from (0,0); `pix_last` when x==w-1 and y==h-1.
- `acc_done` outside WAIT ignored.
- Reset mid-frame: immediate abort, all outputs 0, no `frame_done`.

## Timing
- All outputs registered.
- `start_frame` sampled at edge 0 -> LCR0 outputs visible after edge 1; LCR1 edge 2; LCI0 edge 3; LCI1 edge 4; `acc_start` after edge 5; WAIT from edge 6.
- `acc_done` sampled high at edge N in WAIT -> `pix_valid` after edge N.
- Handshake at edge M -> ADV after M, LCR0 after M+1 (next pixel). Last pixel: DONE after M, `frame_done`=1 for that cycle, `busy` drops with it, IDLE next.
- Per-pixel overhead with immediate ready: 7 cycles plus accelerator latency.
- Timeout pixel leaves WAIT after exactly TIMEOUT+1 WAIT cycles.

## Test plan
- Reset: assert `rst_n`=0 mid-WAIT -> all outputs 0, FSM IDLE, new `start_frame` runs normally.
- Single pixel: w=h=1, x0=0x1000, y0=0xF000; model acc_done after 3 cycles with iter=0x2A -> bytes 00,10 on cr, 00,F0 on ci, one `acc_start`, pix_data=0x2A, pix_last=1, frame_done one cycle after handshake.
- 3x2 grid, x0=0xE000, dx=0x0800, y0=0x1000, dy=0xFC00 -> six pixels in order (0,0)..(2,1); loaded Cr E000,E800,F000 per row; Ci 1000 then 0C00.
- Backpressure: hold `pix_ready`=0 for 10 cycles -> pix_* stable, no accelerator strobes until handshake.
- Timeout: never assert `acc_done`, TIMEOUT=1023 -> pix_data=0xFF after 1024 WAIT cycles; frame continues.
- Edge cases: w=0 -> frame_done one cycle after start with no strobes; start_frame while busy ignored; dx=0x7FFF on w=3 wraps cr to 0xFFFE on third pixel from x0=0.

Source files
------------

// File: rtl/mandel_scan_sequencer.sv
// mandel_scan_sequencer
//   Walks a w x h pixel grid in raster order, loads each pixel's Q4.12 complex
//   coordinate (Cr then Ci, low byte first) into the Mandelbrot core, starts it,
//   waits for done (or a timeout) and emits the iteration count on a
//   valid/ready pixel stream.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   start_frame                one-cycle frame request (honoured only when idle)
//   cfg_x0/cfg_y0/cfg_dx/cfg_dy  Q4.12 origin and per-pixel step
//   cfg_w/cfg_h                grid size in pixels
//   busy, frame_done           frame status
//   acc_load_cr/acc_load_ci/acc_start/acc_data  accelerator strobes and byte bus
//   acc_done/acc_iter          accelerator result
//   pix_valid/pix_ready/pix_data/pix_x/pix_y/pix_last  pixel stream
//
// state  | meaning
// IDLE   | waiting for start_frame; with busy set, one setup cycle from config regs
// LCR0/1 | Cr low / high byte on acc_data with acc_load_cr
// LCI0/1 | Ci low / high byte on acc_data with acc_load_ci
// START  | acc_start pulse
// WAIT   | timeout down-counter running, waiting for acc_done
// OUT    | pixel presented, holding until pix_ready
// ADV    | step to next pixel coordinate
// DONE   | frame_done pulse
module mandel_scan_sequencer #(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_frame,
  input  logic [15:0] cfg_x0,
  input  logic [15:0] cfg_y0,
  input  logic [15:0] cfg_dx,
  input  logic [15:0] cfg_dy,
  input  logic [7:0]  cfg_w,
  input  logic [7:0]  cfg_h,
  output logic        busy,
  output logic        frame_done,
  output logic        acc_load_cr,
  output logic        acc_load_ci,
  output logic        acc_start,
  output logic [7:0]  acc_data,
  input  logic        acc_done,
  input  logic [6:0]  acc_iter,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [7:0]  pix_data,
  output logic [7:0]  pix_x,
  output logic [7:0]  pix_y,
  output logic        pix_last
);

  localparam logic [9:0] TO_CNT = 10'(TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE, S_LCR0, S_LCR1, S_LCI0, S_LCI1, S_START, S_WAIT, S_OUT, S_ADV, S_DONE
  } state_t;

  state_t      state;
  logic [15:0] x0_r, y0_r, dx_r, dy_r;
  logic [7:0]  w_r, h_r;
  logic [15:0] cr, ci;
  logic [7:0]  x, y;
  logic [9:0]  wait_cnt;

  logic        x_wrap, y_last;
  logic [15:0] cr_nxt, ci_nxt;
  logic [7:0]  x_nxt, y_nxt;

  assign x_wrap = (x == w_r - 8'd1);
  assign y_last = (y == h_r - 8'd1);
  assign cr_nxt = x_wrap ? x0_r : cr + dx_r;
  assign ci_nxt = x_wrap ? ci + dy_r : ci;
  assign x_nxt  = x_wrap ? 8'd0 : x + 8'd1;
  assign y_nxt  = x_wrap ? y + 8'd1 : y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      x0_r        <= '0;
      y0_r        <= '0;
      dx_r        <= '0;
      dy_r        <= '0;
      w_r         <= '0;
      h_r         <= '0;
      cr          <= '0;
      ci          <= '0;
      x           <= '0;
      y           <= '0;
      wait_cnt    <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      acc_load_cr <= 1'b0;
      acc_load_ci <= 1'b0;
      acc_start   <= 1'b0;
      acc_data    <= '0;
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_last    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!busy) begin
            if (start_frame) begin
              x0_r <= cfg_x0;
              y0_r <= cfg_y0;
              dx_r <= cfg_dx;
              dy_r <= cfg_dy;
              w_r  <= cfg_w;
              h_r  <= cfg_h;
              busy <= 1'b1;
            end
          end else begin
            // setup cycle: config is now registered, seed the accumulators
            cr <= x0_r;
            ci <= y0_r;
            x  <= '0;
            y  <= '0;
            if (w_r == 8'd0 || h_r == 8'd0) begin
              state      <= S_DONE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              state       <= S_LCR0;
              acc_load_cr <= 1'b1;
              acc_data    <= x0_r[7:0];
            end
          end
        end
        S_LCR0: begin
          acc_data <= cr[15:8];
          state    <= S_LCR1;
        end
        S_LCR1: begin
          acc_load_cr <= 1'b0;
          acc_load_ci <= 1'b1;
          acc_data    <= ci[7:0];
          state       <= S_LCI0;
        end
        S_LCI0: begin
          acc_data <= ci[15:8];
          state    <= S_LCI1;
        end
        S_LCI1: begin
          acc_load_ci <= 1'b0;
          acc_data    <= '0;
          acc_start   <= 1'b1;
          state       <= S_START;
        end
        S_START: begin
          acc_start <= 1'b0;
          wait_cnt  <= TO_CNT;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          // TIMEOUT+1 cycles in WAIT: counter runs TO_CNT down to 0 inclusive
          if (acc_done || wait_cnt == 10'd0) begin
            pix_valid <= 1'b1;
            pix_data  <= acc_done ? {1'b0, acc_iter} : 8'hFF;
            pix_x     <= x;
            pix_y     <= y;
            pix_last  <= x_wrap && y_last;
            state     <= S_OUT;
          end else begin
            wait_cnt <= wait_cnt - 10'd1;
          end
        end
        S_OUT: begin
          if (pix_ready) begin
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_last  <= 1'b0;
            if (pix_last) begin
              state      <= S_DONE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              state <= S_ADV;
            end
          end
        end
        S_ADV: begin
          cr          <= cr_nxt;
          ci          <= ci_nxt;
          x           <= x_nxt;
          y           <= y_nxt;
          acc_load_cr <= 1'b1;
          acc_data    <= cr_nxt[7:0];
          state       <= S_LCR0;
        end
        S_DONE: begin
          frame_done <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mandel_scan_sequencer.sv
module tb_mandel_scan_sequencer;

  localparam int TIMEOUT = 1023;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_frame;
  logic [15:0] cfg_x0, cfg_y0, cfg_dx, cfg_dy;
  logic [7:0]  cfg_w, cfg_h;
  logic        busy, frame_done;
  logic        acc_load_cr, acc_load_ci, acc_start;
  logic [7:0]  acc_data;
  logic        acc_done;
  logic [6:0]  acc_iter;
  logic        pix_valid, pix_ready;
  logic [7:0]  pix_data, pix_x, pix_y;
  logic        pix_last;

  mandel_scan_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start_frame(start_frame),
    .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_dx(cfg_dx), .cfg_dy(cfg_dy),
    .cfg_w(cfg_w), .cfg_h(cfg_h), .busy(busy), .frame_done(frame_done),
    .acc_load_cr(acc_load_cr), .acc_load_ci(acc_load_ci), .acc_start(acc_start),
    .acc_data(acc_data), .acc_done(acc_done), .acc_iter(acc_iter),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         lat;
    logic [6:0] iter;
    bit         to;
  } resp_t;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] data;
    bit         last;
    int         stall;
  } pix_t;

  logic [31:0] coord_q[$];   // {ci, cr}
  resp_t       resp_q[$];
  pix_t        pix_q[$];

  int n_chk = 0;
  int n_pass = 0;
  int fd_cnt = 0;
  int start_cnt = 0;
  int overlap_cnt = 0;
  bit exp_fd_next = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  // frame_done pulse counter
  initial forever begin
    @(negedge clk);
    if (frame_done) fd_cnt++;
  end

  // accelerator model: assembles loaded bytes, checks them at acc_start,
  // then answers after the queued latency (or never, for a timeout pixel)
  initial begin
    logic [15:0] cr_sh, ci_sh;
    logic [31:0] c;
    resp_t r;
    int n;
    cr_sh = '0;
    ci_sh = '0;
    acc_done = 1'b0;
    acc_iter = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cr_sh = '0;
        ci_sh = '0;
        continue;
      end
      if (int'(acc_load_cr) + int'(acc_load_ci) + int'(acc_start) > 1) overlap_cnt++;
      if (acc_load_cr) cr_sh = {acc_data, cr_sh[15:8]};
      if (acc_load_ci) ci_sh = {acc_data, ci_sh[15:8]};
      if (acc_start) begin
        start_cnt++;
        if (coord_q.size() == 0 || resp_q.size() == 0) begin
          check("unexpected_start", 64'(1), 64'(0));
          continue;
        end
        c = coord_q.pop_front();
        r = resp_q.pop_front();
        check("load_cr", 64'(cr_sh), 64'(c[15:0]));
        check("load_ci", 64'(ci_sh), 64'(c[31:16]));
        n = 0;
        do begin
          @(negedge clk);
          n++;
          if (!r.to && n == r.lat) begin
            acc_done = 1'b1;
            acc_iter = r.iter;
          end
        end while (!pix_valid && rst_n && n < 2000);
        if (rst_n) begin
          check("result_latency", 64'(n), r.to ? 64'(TIMEOUT + 2) : 64'(r.lat + 1));
          // keep done high one cycle into OUT with a different count: must be ignored
          acc_iter = ~r.iter;
          @(negedge clk);
        end
        acc_done = 1'b0;
        acc_iter = '0;
      end
    end
  end

  // pixel sink: optional stall per pixel, compares at the handshake
  initial begin
    int   stall;
    pix_t p;
    logic [24:0] snap;
    stall = -1;
    pix_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (exp_fd_next) begin
        check("fd_after_last", 64'(frame_done), 64'(1));
        check("busy_drop_last", 64'(busy), 64'(0));
        exp_fd_next = 0;
      end
      if (!rst_n) begin
        stall = -1;
        pix_ready = 1'b1;
        continue;
      end
      if (!pix_valid) begin
        pix_ready = 1'b1;
        continue;
      end
      if (stall < 0) begin
        if (pix_q.size() == 0) begin
          check("unexpected_pixel", 64'(1), 64'(0));
          pix_ready = 1'b1;
          continue;
        end
        stall = pix_q[0].stall;
        snap = {pix_data, pix_x, pix_y, pix_last};
      end else begin
        check("bp_hold", 64'({pix_data, pix_x, pix_y, pix_last}), 64'(snap));
        check("bp_no_strobe", 64'({acc_load_cr, acc_load_ci, acc_start}), 64'(0));
      end
      if (stall > 0) begin
        pix_ready = 1'b0;
        stall--;
      end else begin
        pix_ready = 1'b1;
        p = pix_q.pop_front();
        check("pix_x", 64'(pix_x), 64'(p.x));
        check("pix_y", 64'(pix_y), 64'(p.y));
        check("pix_data", 64'(pix_data), 64'(p.data));
        check("pix_last", 64'(pix_last), 64'(p.last));
        if (p.last) exp_fd_next = 1;
        stall = -1;
      end
    end
  end

  function automatic logic [38:0] all_outs();
    return {busy, frame_done, acc_load_cr, acc_load_ci, acc_start, acc_data,
            pix_valid, pix_data, pix_x, pix_y, pix_last};
  endfunction

  task automatic push_frame(input logic [15:0] x0, y0, dx, dy, input logic [7:0] w, h,
                            input int seed, input int stall_at, input int to_at);
    resp_t r;
    pix_t  p;
    int    idx;
    idx = 0;
    for (int yy = 0; yy < int'(h); yy++) begin
      for (int xx = 0; xx < int'(w); xx++) begin
        coord_q.push_back({16'(y0 + 16'(yy) * dy), 16'(x0 + 16'(xx) * dx)});
        r.lat  = 1 + ((xx + yy + seed) % 4);
        r.iter = 7'(xx * 7 + yy * 13 + seed);
        r.to   = (idx == to_at);
        resp_q.push_back(r);
        p.x     = 8'(xx);
        p.y     = 8'(yy);
        p.data  = r.to ? 8'hFF : {1'b0, r.iter};
        p.last  = (xx == int'(w) - 1) && (yy == int'(h) - 1);
        p.stall = (idx == stall_at) ? 10 : 0;
        pix_q.push_back(p);
        idx++;
      end
    end
  endtask

  task automatic pulse_start(input logic [15:0] x0, y0, dx, dy, input logic [7:0] w, h);
    @(negedge clk);
    cfg_x0 = x0; cfg_y0 = y0; cfg_dx = dx; cfg_dy = dy; cfg_w = w; cfg_h = h;
    start_frame = 1'b1;
    @(negedge clk);
    start_frame = 1'b0;
    // scramble config: the running frame must not see it
    cfg_x0 = 16'($urandom); cfg_y0 = 16'($urandom);
    cfg_dx = 16'($urandom); cfg_dy = 16'($urandom);
    cfg_w  = 8'($urandom);  cfg_h  = 8'($urandom);
  endtask

  task automatic flush_queues();
    coord_q.delete();
    resp_q.delete();
    pix_q.delete();
  endtask

  task automatic run_frame(input logic [15:0] x0, y0, dx, dy, input logic [7:0] w, h,
                           input int seed, input int stall_at, input int to_at);
    int fd0, st0, ov0, n;
    fd0 = fd_cnt;
    st0 = start_cnt;
    ov0 = overlap_cnt;
    push_frame(x0, y0, dx, dy, w, h, seed, stall_at, to_at);
    pulse_start(x0, y0, dx, dy, w, h);
    check("busy_rise", 64'(busy), 64'(1));
    check("no_early_strobe", 64'({frame_done, acc_load_cr, acc_load_ci, acc_start}), 64'(0));
    @(negedge clk);
    if (w == 8'd0 || h == 8'd0) begin
      check("empty_fd", 64'(frame_done), 64'(1));
      check("empty_busy", 64'(busy), 64'(0));
    end else begin
      check("lcr0_strobe", 64'({acc_load_cr, acc_load_ci}), 64'(2'b10));
      check("lcr0_byte", 64'(acc_data), 64'(x0[7:0]));
    end
    n = 0;
    while (fd_cnt == fd0 && n < 20000) begin
      @(negedge clk);
      n++;
      start_frame = (n == 6);   // request while busy must be ignored
    end
    start_frame = 1'b0;
    check("frame_in_time", 64'(n < 20000), 64'(1));
    repeat (4) @(negedge clk);
    check("fd_count", 64'(fd_cnt - fd0), 64'(1));
    check("start_count", 64'(start_cnt - st0), 64'(int'(w) * int'(h)));
    check("pix_drained", 64'(pix_q.size()), 64'(0));
    check("idle_after", 64'(busy), 64'(0));
    check("strobe_overlap", 64'(overlap_cnt - ov0), 64'(0));
    flush_queues();
  endtask

  initial begin
    int fd0;
    rst_n = 1'b0;
    start_frame = 1'b0;
    cfg_x0 = '0; cfg_y0 = '0; cfg_dx = '0; cfg_dy = '0; cfg_w = '0; cfg_h = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(all_outs()), 64'(0));
    rst_n = 1'b1;

    // single pixel
    run_frame(16'h1000, 16'hF000, 16'h0000, 16'h0000, 8'd1, 8'd1, 42, -1, -1);
    // 3x2 grid
    run_frame(16'hE000, 16'h1000, 16'h0800, 16'hFC00, 8'd3, 8'd2, 5, -1, -1);
    // backpressure on an interior pixel
    run_frame(16'h0123, 16'h0456, 16'h0011, 16'h0022, 8'd2, 8'd2, 9, 2, -1);
    // timeout on first pixel, frame continues
    run_frame(16'h2000, 16'h3000, 16'h0100, 16'h0100, 8'd2, 8'd1, 3, -1, 0);
    // empty grids
    run_frame(16'h1111, 16'h2222, 16'h0001, 16'h0001, 8'd0, 8'd4, 1, -1, -1);
    run_frame(16'h1111, 16'h2222, 16'h0001, 16'h0001, 8'd3, 8'd0, 1, -1, -1);
    // coordinate wrap modulo 2^16
    run_frame(16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 8'd3, 8'd1, 7, -1, -1);

    // reset mid-WAIT (timeout pixel keeps it waiting)
    fd0 = fd_cnt;
    push_frame(16'h4000, 16'h5000, 16'h0010, 16'h0010, 8'd2, 8'd1, 2, -1, 0);
    pulse_start(16'h4000, 16'h5000, 16'h0010, 16'h0010, 8'd2, 8'd1);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_mid_wait", 64'(all_outs()), 64'(0));
    flush_queues();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("no_fd_after_abort", 64'(fd_cnt - fd0), 64'(0));
    check("idle_after_abort", 64'(all_outs()), 64'(0));
    run_frame(16'hE000, 16'h1000, 16'h0800, 16'hFC00, 8'd3, 8'd2, 11, 4, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
